// File: rtl/sqrt_issue_arbiter_if.sv
// Handshake bundle between the FPU issue logic, the sqrt issue arbiter and the
// sqrt datapath: request side, pipeline side and tagged response side.
interface sqrt_issue_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_x;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        sq_x;
  logic [31:0]        sq_y;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_y;
  logic [NREQ-1:0]    rsp_ready;
  logic               busy;

  // Requester/datapath side of the bundle
  modport master (
    output req_valid, req_x, sq_y, rsp_ready,
    input  req_ready, sq_x, rsp_valid, rsp_y, busy
  );

  // Arbiter side of the bundle
  modport slave (
    input  req_valid, req_x, sq_y, rsp_ready,
    output req_ready, sq_x, rsp_valid, rsp_y, busy
  );
endinterface

// File: rtl/sqrt_issue_arbiter.sv
// Round-robin issue arbiter for a shared fixed-latency sqrt pipeline with a tagged,
// credit-protected result FIFO. Optional counters enabled by SQRT_ARB_STATS_EN.
module sqrt_issue_arbiter #(
  parameter int NREQ    = 2,
  parameter int LATENCY = 6,
  parameter int DEPTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  sqrt_issue_arbiter_if.slave bus
`ifdef SQRT_ARB_STATS_EN
  ,
  output logic [31:0]         issue_cnt,
  output logic [31:0]         stall_cnt
`endif
);
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(LATENCY + 1);

  logic [31:0]    operand [NREQ];
  logic           sr_valid_reg [LATENCY];
  logic [TW-1:0]  sr_tag_reg [LATENCY];
  logic [IW-1:0]  inflight;
  logic [31:0]    occupancy;
  logic           credit_ok;

  logic [TW-1:0]  rr_ptr_reg;
  logic [TW-1:0]  rr_ptr_next;
  logic [TW-1:0]  winner;
  logic           grant_found;
  logic           grant;
  int             scan_idx;

  logic [31:0]    fifo_data [DEPTH];
  logic [TW-1:0]  fifo_tag [DEPTH];
  logic [PW-1:0]  wr_ptr_reg;
  logic [PW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  fifo_cnt_reg;
  logic [31:0]    last_y_reg;
  logic [31:0]    head_data;
  logic [TW-1:0]  head_tag;
  logic           empty;
  logic           push;
  logic           pop;
  logic [NREQ-1:0] rsp_valid_vec;
  logic [NREQ-1:0] grant_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign operand[gi]       = bus.req_x[32*gi +: 32];
      assign grant_vec[gi]     = grant && (winner == TW'(gi));
      assign rsp_valid_vec[gi] = !empty && (head_tag == TW'(gi));
    end
  endgenerate

  // Credits are taken from registered state only, so a pop frees a slot one cycle later.
  always_comb begin
    inflight = '0;
    for (int s = 0; s < LATENCY; s++) begin
      inflight = inflight + IW'(sr_valid_reg[s]);
    end
  end

  assign occupancy = 32'(fifo_cnt_reg) + 32'(inflight);
  assign credit_ok = occupancy < 32'(DEPTH);

  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    scan_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (int'(rr_ptr_reg) + k) % NREQ;
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        winner      = TW'(scan_idx);
      end
    end
  end

  assign grant       = grant_found && credit_ok && !rst;
  assign rr_ptr_next = (winner == TW'(NREQ - 1)) ? '0 : winner + TW'(1);

  assign bus.req_ready = grant_vec;
  assign bus.sq_x      = grant ? operand[winner] : 32'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (grant) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Valid/tag shadow of the sqrt pipeline; it never stalls, matching the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        sr_valid_reg[s] <= 1'b0;
        sr_tag_reg[s]   <= '0;
      end
    end else begin
      for (int s = LATENCY - 1; s > 0; s--) begin
        sr_valid_reg[s] <= sr_valid_reg[s-1];
        sr_tag_reg[s]   <= sr_tag_reg[s-1];
      end
      sr_valid_reg[0] <= grant;
      sr_tag_reg[0]   <= winner;
    end
  end

  assign push      = sr_valid_reg[LATENCY-1];
  assign empty     = (fifo_cnt_reg == '0);
  assign head_data = fifo_data[rd_ptr_reg];
  assign head_tag  = fifo_tag[rd_ptr_reg];
  assign pop       = |(rsp_valid_vec & bus.rsp_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_reg] <= bus.sq_y;
      fifo_tag[wr_ptr_reg]  <= sr_tag_reg[LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      last_y_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
        last_y_reg <= head_data;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CW'(1);
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CW'(1);
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // While empty the response bus keeps showing the most recently delivered result.
  assign bus.rsp_valid = rsp_valid_vec;
  assign bus.rsp_y     = empty ? last_y_reg : head_data;
  assign bus.busy      = (inflight != '0) || (fifo_cnt_reg != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (fifo_cnt_reg == CW'(DEPTH))));

`ifdef SQRT_ARB_STATS_EN
  logic [31:0] issue_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (grant && (issue_cnt_reg != 32'hFFFF_FFFF)) begin
        issue_cnt_reg <= issue_cnt_reg + 32'd1;
      end
      if ((|bus.req_valid) && !credit_ok && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign issue_cnt = issue_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_sqrt_issue_arbiter.sv
// Bench for sqrt_issue_arbiter: a queue-based model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_sqrt_issue_arbiter;
  localparam int NREQ    = 2;
  localparam int LATENCY = 6;
  localparam int DEPTH   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sqrt_issue_arbiter_if #(.NREQ(NREQ)) bus ();

`ifdef SQRT_ARB_STATS_EN
  logic [31:0] issue_cnt;
  logic [31:0] stall_cnt;
`endif

  sqrt_issue_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef SQRT_ARB_STATS_EN
    ,
    .issue_cnt(issue_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Datapath stand-in: exact roots for the tabled operands, a tagged mapping otherwise.
  function automatic logic [31:0] sqrt_ref(input logic [31:0] x);
    case (x)
      32'h3F80_0000: return 32'h3F80_0000;
      32'h4080_0000: return 32'h4000_0000;
      32'h4180_0000: return 32'h4080_0000;
      32'h4110_0000: return 32'h4040_0000;
      default:       return {8'hC3, x[23:0]};
    endcase
  endfunction

  logic [31:0] pipe [LATENCY];
  always @(posedge clk) begin
    pipe[0] <= sqrt_ref(bus.sq_x);
    for (int s = 1; s < LATENCY; s++) pipe[s] <= pipe[s-1];
  end
  assign bus.sq_y = pipe[LATENCY-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: operations in flight become visible in the FIFO at a known cycle.
  typedef struct {
    int          ready;
    int          tag;
    logic [31:0] data;
  } ent_t;

  ent_t        inflight_q[$];
  ent_t        fifo_q[$];
  int          rr     = 0;
  int          cyc    = 0;
  logic [31:0] last_y = '0;

  function automatic bit landing_now();
    foreach (inflight_q[i]) if (inflight_q[i].ready == cyc + 1) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    int          win;
    int          idx;
    logic [31:0] e_ready;
    logic [31:0] e_sqx;
    logic [31:0] e_rv;
    logic [31:0] e_y;
    ent_t        e;
    if (rst) begin
      inflight_q.delete();
      fifo_q.delete();
      rr     = 0;
      last_y = '0;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_sq_x", bus.sq_x, 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_y", bus.rsp_y, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
    end else begin
      while (inflight_q.size() > 0 && inflight_q[0].ready <= cyc)
        fifo_q.push_back(inflight_q.pop_front());
      win = -1;
      if (fifo_q.size() + inflight_q.size() < DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (rr + k) % NREQ;
          if (win < 0 && bus.req_valid[idx]) win = idx;
        end
      end
      e_ready = (win >= 0) ? (32'd1 << win) : 32'd0;
      e_sqx   = (win >= 0) ? bus.req_x[32*win +: 32] : 32'd0;
      e_rv    = (fifo_q.size() > 0) ? (32'd1 << fifo_q[0].tag) : 32'd0;
      e_y     = (fifo_q.size() > 0) ? fifo_q[0].data : last_y;
      chk("req_ready", 32'(bus.req_ready), e_ready);
      chk("sq_x", bus.sq_x, e_sqx);
      chk("rsp_valid", 32'(bus.rsp_valid), e_rv);
      chk("rsp_y", bus.rsp_y, e_y);
      chk("busy", 32'(bus.busy), (fifo_q.size() + inflight_q.size() > 0) ? 32'd1 : 32'd0);
      chk("fifo_cnt", 32'(dut.fifo_cnt_reg), 32'(fifo_q.size()));
      if (win >= 0) begin
        e.ready = cyc + LATENCY + 1;
        e.tag   = win;
        e.data  = sqrt_ref(e_sqx);
        inflight_q.push_back(e);
        rr = (win + 1) % NREQ;
      end
      if (fifo_q.size() > 0 && bus.rsp_ready[fifo_q[0].tag]) begin
        last_y = fifo_q[0].data;
        $display("rsp cycle=%0d tag=%0d y=%h", cyc, fifo_q[0].tag, fifo_q[0].data);
        void'(fifo_q.pop_front());
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int g;
    int g2;
    int p;
    int pp;
    bit granted;
    bus.req_valid = 2'b01;
    bus.req_x     = '0;
    bus.rsp_ready = 2'b00;
    repeat (2) tick();
    chk("reset_req_ready_gated", 32'(bus.req_ready), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    bus.req_valid = 2'b00;
    tick();

    // Single request: 4.0 -> 2.0, visible LATENCY+1 cycles after issue.
    bus.rsp_ready = 2'b11;
    bus.req_x[31:0] = 32'h4080_0000;
    bus.req_valid = 2'b01;
    @(negedge clk);
    chk("single_grant", 32'(bus.req_ready), 32'd1);
    chk("single_sq_x", bus.sq_x, 32'h4080_0000);
    tick();
    bus.req_valid = 2'b00;
    repeat (5) tick();
    @(negedge clk);
    chk("single_not_early", 32'(bus.rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_rsp_y", bus.rsp_y, 32'h4000_0000);
    repeat (3) tick();

    // Round-robin from a fresh pointer.
    pulse_reset();
    bus.req_x = {32'h4180_0000, 32'h3F80_0000};
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k >= 7) begin
        chk("rr_rsp_valid", 32'(bus.rsp_valid), ((k - 7) % 2 == 0) ? 32'd1 : 32'd2);
        chk("rr_rsp_y", bus.rsp_y, ((k - 7) % 2 == 0) ? 32'h3F80_0000 : 32'h4080_0000);
      end
      tick();
    end
    bus.req_valid = 2'b00;
    repeat (10) tick();

    // Back-pressure: exactly DEPTH grants, then drain in order and resume.
    bus.rsp_ready = 2'b00;
    bus.req_x[31:0] = 32'h4110_0000;
    bus.req_valid = 2'b01;
    g = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      granted = bus.req_ready[0];
      if (granted) g++;
      tick();
      if (granted) bus.req_x[31:0] = 32'h4110_0000 + 32'(g);
    end
    chk("bp_grants", 32'(g), 32'(DEPTH));
    @(negedge clk);
    chk("bp_stalled", 32'(bus.req_ready), 32'd0);
    tick();
    bus.rsp_ready = 2'b01;
    g2 = 0;
    p  = 0;
    for (int k = 0; k < 44; k++) begin
      if (k == 24) bus.req_valid = 2'b00;
      @(negedge clk);
      granted = bus.req_ready[0];
      if (granted) g2++;
      if (bus.rsp_valid[0]) p++;
      tick();
      if (granted) bus.req_x[31:0] = 32'h4110_0000 + 32'(g + g2);
    end
    chk("bp_resume", (g2 > 0) ? 32'd1 : 32'd0, 32'd1);
    chk("bp_all_delivered", 32'(p), 32'(DEPTH + g2));

    // Head-of-line: requester 1's result blocks requester 0's.
    bus.rsp_ready = 2'b01;
    bus.req_x = {32'h4180_0000, 32'h4080_0000};
    bus.req_valid = 2'b10;
    @(negedge clk);
    chk("hol_grant1", 32'(bus.req_ready), 32'd2);
    tick();
    bus.req_valid = 2'b01;
    @(negedge clk);
    chk("hol_grant0", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 2'b00;
    repeat (15) tick();
    @(negedge clk);
    chk("hol_blocked_valid", 32'(bus.rsp_valid), 32'd2);
    chk("hol_blocked_y", bus.rsp_y, 32'h4080_0000);
    tick();
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    chk("hol_head_still", 32'(bus.rsp_valid), 32'd2);
    tick();
    @(negedge clk);
    chk("hol_next_valid", 32'(bus.rsp_valid), 32'd1);
    chk("hol_next_y", bus.rsp_y, 32'h4000_0000);
    repeat (4) tick();

    // Reset with three operations in flight.
    bus.req_x[31:0] = 32'h3F80_0000;
    bus.req_valid = 2'b01;
    repeat (3) tick();
    chk("midrst_busy_before", 32'(bus.busy), 32'd1);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(bus.rsp_valid), 32'd0);
      tick();
    end

    // Hold occupancy at DEPTH-1 while pushes and pops coincide; pointers wrap.
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b01;
    g = 0;
    for (int k = 0; k < 20 && g < DEPTH - 1; k++) begin
      @(negedge clk);
      if (bus.req_ready[0]) g++;
      tick();
      if (g == DEPTH - 1) bus.req_valid = 2'b00;
    end
    repeat (LATENCY + 2) tick();
    @(negedge clk);
    chk("full1_cnt", 32'(dut.fifo_cnt_reg), 32'(DEPTH - 1));
    tick();
    bus.req_valid = 2'b01;
    pp = 0;
    for (int k = 0; k < 28; k++) begin
      bus.rsp_ready = landing_now() ? 2'b01 : 2'b00;
      @(negedge clk);
      chk("full1_cnt_hold", 32'(dut.fifo_cnt_reg), 32'(DEPTH - 1));
      if (bus.rsp_ready[0]) pp++;
      tick();
    end
    chk("full1_pushpops", 32'(pp), 32'd4);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b01;
    repeat (20) tick();
    @(negedge clk);
    chk("final_idle_busy", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
